// File: rtl/rst_seq_pkg.sv
// Shared types and default parameters for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {S_ASSERT, S_RELEASE, S_RUN, S_QUIESCE} rst_seq_state_e;

  localparam int DEF_N_STAGE  = 3;
  localparam int DEF_HOLD_CYC = 8;
  localparam int DEF_GAP_CYC  = 4;
  localparam int DEF_QTO_CYC  = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rst.sv
// Two-flop reset synchronizer: asynchronous assertion, release aligned to clk.
module rst (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic ff1_r;
  logic ff2_r;

  // Shift a constant one through two flops once rst_n releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff1_r <= 1'b0;
      ff2_r <= 1'b0;
    end else begin
      ff1_r <= 1'b1;
      ff2_r <= ff1_r;
    end
  end

  assign rst_n_sync = ff2_r;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronizes the board reset, releases downstream domains in order
// and runs the quiesce / soft-reset handshake.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int N_STAGE  = DEF_N_STAGE,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int QTO_CYC  = DEF_QTO_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               soft_rst_req,
  input  logic               quiesce_ack,
  output logic               quiesce_req,
  output logic               soft_rst_ack,
  output logic [N_STAGE-1:0] rst_n_stage,
  output logic               sys_ready,
  output logic               qto_flag
);

  localparam int CNT_W = $clog2(max3(HOLD_CYC, GAP_CYC, QTO_CYC) + 1);
  localparam int IDX_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] QTO_LAST  = CNT_W'(QTO_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGE - 1);

  logic               rst_n_sync_s;
  rst_seq_state_e     state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic               soft_pend_r, soft_pend_s;
  logic [N_STAGE-1:0] stage_r, stage_s;
  logic               qreq_r, qreq_s;
  logic               ack_r, ack_s;
  logic               ready_r, ready_s;
  logic               qto_r, qto_s;

  rst u_rst (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_n_sync (rst_n_sync_s)
  );

  // State and output registers, cleared asynchronously by the synchronized reset.
  always_ff @(posedge clk or negedge rst_n_sync_s) begin
    if (!rst_n_sync_s) begin
      state_r     <= S_ASSERT;
      cnt_r       <= {CNT_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      soft_pend_r <= 1'b0;
      stage_r     <= {N_STAGE{1'b0}};
      qreq_r      <= 1'b0;
      ack_r       <= 1'b0;
      ready_r     <= 1'b0;
      qto_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      soft_pend_r <= soft_pend_s;
      stage_r     <= stage_s;
      qreq_r      <= qreq_s;
      ack_r       <= ack_s;
      ready_r     <= ready_s;
      qto_r       <= qto_s;
    end
  end

  // Next-state and next-output logic; the single cnt is reused by every timed state.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    soft_pend_s = soft_pend_r;
    stage_s     = stage_r;
    qreq_s      = qreq_r;
    ack_s       = 1'b0;
    ready_s     = ready_r;
    qto_s       = qto_r;
    case (state_r)
      S_ASSERT: begin
        stage_s = {N_STAGE{1'b0}};
        if (cnt_r == HOLD_LAST) begin
          state_s = S_RELEASE;
          cnt_s   = {CNT_W{1'b0}};
          idx_s   = {IDX_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (cnt_r == GAP_LAST) begin
          stage_s[idx_r] = 1'b1;
          cnt_s          = {CNT_W{1'b0}};
          if (idx_r == IDX_LAST) begin
            state_s     = S_RUN;
            ready_s     = 1'b1;
            ack_s       = soft_pend_r;
            soft_pend_s = 1'b0;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_RUN: begin
        if (soft_rst_req) begin
          state_s     = S_QUIESCE;
          qreq_s      = 1'b1;
          ready_s     = 1'b0;
          soft_pend_s = 1'b1;
          cnt_s       = {CNT_W{1'b0}};
        end else begin
          ready_s = 1'b1;
        end
      end
      S_QUIESCE: begin
        // Ack has priority over a timeout sampled on the same edge.
        if (quiesce_ack || (cnt_r == QTO_LAST)) begin
          state_s = S_ASSERT;
          stage_s = {N_STAGE{1'b0}};
          qreq_s  = 1'b0;
          cnt_s   = {CNT_W{1'b0}};
          qto_s   = qto_r | ~quiesce_ack;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = S_ASSERT;
        stage_s = {N_STAGE{1'b0}};
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign rst_n_stage  = stage_r;
  assign quiesce_req  = qreq_r;
  assign soft_rst_ack = ack_r;
  assign sys_ready    = ready_r;
  assign qto_flag     = qto_r;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: timeline-based reference model plus a
// small-parameter corner instance.
module tb_rst_seq_ctrl;

  localparam int N    = 3;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int QTO  = 64;
  localparam int MODE_SEQ = 0;
  localparam int MODE_RUN = 1;
  localparam int MODE_Q   = 2;

  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic rst_n = 1'b0;
  logic soft_rst_req = 1'b0;
  logic quiesce_ack = 1'b0;
  logic [N-1:0] rst_n_stage;
  logic quiesce_req, soft_rst_ack, sys_ready, qto_flag;

  logic rst_n2 = 1'b0;
  logic [0:0] c_stage;
  logic c_qreq, c_ack, c_ready, c_qto;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state: synchronizer, phase and elapsed time within phase.
  logic m_s1 = 1'b0, m_s2 = 1'b0;
  int m_mode = MODE_SEQ;
  int m_t = 0;
  int m_q = 0;
  logic m_pend = 1'b0;
  logic [N-1:0] m_stage = '0;
  logic m_qreq = 1'b0, m_ack = 1'b0, m_ready = 1'b0, m_qto = 1'b0;

  wire [N+3:0] dut_v = {rst_n_stage, quiesce_req, soft_rst_ack, sys_ready, qto_flag};
  wire [4:0]   c_v   = {c_stage, c_qreq, c_ack, c_ready, c_qto};

  rst_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .quiesce_ack(quiesce_ack),
    .quiesce_req(quiesce_req), .soft_rst_ack(soft_rst_ack), .rst_n_stage(rst_n_stage),
    .sys_ready(sys_ready), .qto_flag(qto_flag)
  );

  rst_seq_ctrl #(.N_STAGE(1), .HOLD_CYC(1), .GAP_CYC(1), .QTO_CYC(2)) dut_c (
    .clk(clk), .rst_n(rst_n2), .soft_rst_req(1'b0), .quiesce_ack(1'b0),
    .quiesce_req(c_qreq), .soft_rst_ack(c_ack), .rst_n_stage(c_stage),
    .sys_ready(c_ready), .qto_flag(c_qto)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic logic [N+3:0] exp_v();
    return {m_stage, m_qreq, m_ack, m_ready, m_qto};
  endfunction

  task automatic model_clear();
    m_mode = MODE_SEQ; m_t = 0; m_q = 0; m_pend = 1'b0; m_stage = '0;
    m_qreq = 1'b0; m_ack = 1'b0; m_ready = 1'b0; m_qto = 1'b0;
  endtask

  task automatic model_async_reset();
    m_s1 = 1'b0; m_s2 = 1'b0;
    model_clear();
  endtask

  // Stage k is released once HOLD + (k+1)*GAP cycles have elapsed since the sequence began.
  task automatic model_step();
    logic sync_now;
    sync_now = m_s2;
    if (!rst_n) begin m_s1 = 1'b0; m_s2 = 1'b0; end
    else begin m_s2 = m_s1; m_s1 = 1'b1; end
    if (!sync_now) begin
      model_clear();
    end else begin
      m_ack = 1'b0;
      case (m_mode)
        MODE_SEQ: begin
          m_t++;
          for (int k = 0; k < N; k++) m_stage[k] = (m_t >= HOLD + (k + 1) * GAP);
          if (m_t == HOLD + N * GAP) begin
            m_mode = MODE_RUN; m_ready = 1'b1; m_ack = m_pend; m_pend = 1'b0;
          end
        end
        MODE_RUN: begin
          if (soft_rst_req) begin
            m_mode = MODE_Q; m_q = 0; m_qreq = 1'b1; m_ready = 1'b0; m_pend = 1'b1;
          end
        end
        default: begin
          if (quiesce_ack || m_q == QTO - 1) begin
            if (!quiesce_ack) m_qto = 1'b1;
            m_mode = MODE_SEQ; m_t = 0; m_stage = '0; m_qreq = 1'b0;
          end else begin
            m_q++;
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_async_reset();
    #1;
    total_cnt++;
    if (dut_v !== exp_v()) $display("FAIL reset_async: got %b want %b", dut_v, exp_v());
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (dut_v !== exp_v()) $display("FAIL reset_hold cyc %0d: got %b want %b", i, dut_v, exp_v());
      else pass_cnt++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_power_on();
    int rise[N];
    int ready_at;
    int ack_seen;
    for (int k = 0; k < N; k++) rise[k] = -1;
    ready_at = -1;
    ack_seen = 0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      total_cnt++;
      if (dut_v !== exp_v()) $display("FAIL power_on edge %0d: got %b want %b", e, dut_v, exp_v());
      else pass_cnt++;
      for (int k = 0; k < N; k++) if (rise[k] < 0 && rst_n_stage[k] === 1'b1) rise[k] = e;
      if (ready_at < 0 && sys_ready === 1'b1) ready_at = e;
      if (soft_rst_ack !== 1'b0) ack_seen++;
    end
    // Two synchronizer edges precede cycle 0 of the sequence.
    for (int k = 0; k < N; k++) begin
      total_cnt++;
      if (rise[k] != 2 + HOLD + (k + 1) * GAP)
        $display("FAIL power_on_stage%0d_edge: got %0d want %0d", k, rise[k], 2 + HOLD + (k + 1) * GAP);
      else pass_cnt++;
    end
    total_cnt++;
    if (ready_at != 2 + HOLD + N * GAP)
      $display("FAIL power_on_ready_edge: got %0d want %0d", ready_at, 2 + HOLD + N * GAP);
    else pass_cnt++;
    total_cnt++;
    if (ack_seen != 0) $display("FAIL power_on_no_ack: got %0d pulses want 0", ack_seen);
    else pass_cnt++;
  endtask

  task automatic test_soft_ack();
    int acks;
    int rise0;
    for (int i = 0; i < int'($urandom_range(0, 4)); i++) tick();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    total_cnt++;
    if (quiesce_req !== 1'b1) $display("FAIL soft_ack_qreq: got %b want 1", quiesce_req);
    else pass_cnt++;
    tick(); tick();
    quiesce_ack = 1'b1;
    tick();
    quiesce_ack = 1'b0;
    total_cnt++;
    if (rst_n_stage !== '0) $display("FAIL soft_ack_stages_low: got %b want 000", rst_n_stage);
    else pass_cnt++;
    acks = 0;
    rise0 = -1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      total_cnt++;
      if (dut_v !== exp_v()) $display("FAIL soft_ack edge %0d: got %b want %b", e, dut_v, exp_v());
      else pass_cnt++;
      if (soft_rst_ack === 1'b1) acks++;
      if (rise0 < 0 && rst_n_stage[0] === 1'b1) rise0 = e;
    end
    total_cnt++;
    if (acks != 1 || rise0 != HOLD + GAP || qto_flag !== 1'b0)
      $display("FAIL soft_ack_summary: got acks=%0d rise0=%0d qto=%b want 1/%0d/0", acks, rise0, qto_flag, HOLD + GAP);
    else pass_cnt++;
  endtask

  task automatic test_ack_timeout();
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    for (int i = 0; i < QTO + 4 && m_q != QTO - 1; i++) begin
      tick();
      total_cnt++;
      if (dut_v !== exp_v()) $display("FAIL ack_tmo_wait cyc %0d: got %b want %b", i, dut_v, exp_v());
      else pass_cnt++;
    end
    quiesce_ack = 1'b1;
    tick();
    quiesce_ack = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      total_cnt++;
      if (dut_v !== exp_v()) $display("FAIL ack_tmo_seq cyc %0d: got %b want %b", i, dut_v, exp_v());
      else pass_cnt++;
    end
    total_cnt++;
    if (qto_flag !== 1'b0 || sys_ready !== 1'b1)
      $display("FAIL ack_tmo_flags: got qto=%b ready=%b want 0/1", qto_flag, sys_ready);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int fall_at;
    int acks;
    fall_at = -1;
    acks = 0;
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    for (int e = 1; e <= QTO + 30; e++) begin
      tick();
      total_cnt++;
      if (dut_v !== exp_v()) $display("FAIL timeout edge %0d: got %b want %b", e, dut_v, exp_v());
      else pass_cnt++;
      if (fall_at < 0 && quiesce_req === 1'b0) fall_at = e;
      if (soft_rst_ack === 1'b1) acks++;
    end
    total_cnt++;
    if (fall_at != QTO || qto_flag !== 1'b1 || sys_ready !== 1'b1 || acks != 1)
      $display("FAIL timeout_summary: got fall=%0d qto=%b ready=%b acks=%0d want %0d/1/1/1",
               fall_at, qto_flag, sys_ready, acks, QTO);
    else pass_cnt++;
  endtask

  task automatic test_random_soft();
    int d;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
      soft_rst_req = 1'b1;
      tick();
      soft_rst_req = 1'b0;
      d = int'($urandom_range(0, QTO + 4));
      for (int j = 0; j < d; j++) begin
        tick();
        total_cnt++;
        if (dut_v !== exp_v()) $display("FAIL random it%0d q%0d: got %b want %b", it, j, dut_v, exp_v());
        else pass_cnt++;
      end
      quiesce_ack = 1'b1;
      tick();
      quiesce_ack = 1'b0;
      for (int j = 0; j < 40 && m_mode != MODE_RUN; j++) begin
        tick();
        total_cnt++;
        if (dut_v !== exp_v()) $display("FAIL random it%0d s%0d: got %b want %b", it, j, dut_v, exp_v());
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int ready_at;
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    quiesce_ack = 1'b1;
    tick();
    quiesce_ack = 1'b0;
    for (int i = 0; i < 40 && m_t != HOLD + GAP + 1; i++) tick();
    total_cnt++;
    if (rst_n_stage !== 3'b001) $display("FAIL mid_pre_stop: got %b want 001", rst_n_stage);
    else pass_cnt++;
    clk_en = 1'b0;
    #7;
    rst_n = 1'b0;
    model_async_reset();
    #1;
    total_cnt++;
    if (dut_v !== {(N + 4){1'b0}}) $display("FAIL mid_async_clear: got %b want all 0", dut_v);
    else pass_cnt++;
    #20;
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    ready_at = -1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      total_cnt++;
      if (dut_v !== exp_v()) $display("FAIL mid_restart edge %0d: got %b want %b", e, dut_v, exp_v());
      else pass_cnt++;
      if (ready_at < 0 && sys_ready === 1'b1) ready_at = e;
    end
    total_cnt++;
    if (ready_at != 2 + HOLD + N * GAP || qto_flag !== 1'b0)
      $display("FAIL mid_restart_ready: got edge=%0d qto=%b want %0d/0", ready_at, qto_flag, 2 + HOLD + N * GAP);
    else pass_cnt++;
  endtask

  task automatic test_req_ignored();
    int ready_at;
    rst_n = 1'b0;
    model_async_reset();
    soft_rst_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    ready_at = -1;
    for (int e = 1; e <= 40 && ready_at < 0; e++) begin
      tick();
      total_cnt++;
      if (dut_v !== exp_v()) $display("FAIL req_ignored edge %0d: got %b want %b", e, dut_v, exp_v());
      else pass_cnt++;
      if (sys_ready === 1'b1) ready_at = e;
    end
    total_cnt++;
    if (ready_at != 2 + HOLD + N * GAP) $display("FAIL req_ignored_ready: got %0d want %0d", ready_at, 2 + HOLD + N * GAP);
    else pass_cnt++;
    // Still held on entry to run: a new soft sequence must start.
    tick();
    soft_rst_req = 1'b0;
    total_cnt++;
    if (quiesce_req !== 1'b1 || sys_ready !== 1'b0)
      $display("FAIL req_held_starts: got qreq=%b ready=%b want 1/0", quiesce_req, sys_ready);
    else pass_cnt++;
    quiesce_ack = 1'b1;
    tick();
    quiesce_ack = 1'b0;
    for (int j = 0; j < 30; j++) begin
      tick();
      total_cnt++;
      if (dut_v !== exp_v()) $display("FAIL req_held_seq cyc %0d: got %b want %b", j, dut_v, exp_v());
      else pass_cnt++;
    end
  endtask

  task automatic test_corner();
    logic [4:0] want;
    total_cnt++;
    if (c_v !== 5'b00000) $display("FAIL corner_reset: got %b want 00000", c_v);
    else pass_cnt++;
    rst_n2 = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      want = (e >= 4) ? 5'b10010 : 5'b00000;
      total_cnt++;
      if (c_v !== want) $display("FAIL corner edge %0d: got %b want %b", e, c_v, want);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_soft_ack();
    test_ack_timeout();
    test_timeout();
    test_random_soft();
    test_reset_mid();
    test_req_ignored();
    test_corner();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
